scan_chain_uart_client: RTL and testbench

UART-to-scan-chain write bridge. It receives fixed-size scan write packets over an 8N1 serial link and presents each packet as one address/payload write on a valid/ready port toward the scan-chain driver. It returns a one-byte acknowledge to the host saying whether the write was accepted. It sits between the host UART pins and the scan-chain controller, and instantiates the codebase `uart` transceiver internally.

---
 rtl/scan_chain_uart_client.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_scan_chain_uart_client.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_uart_client.sv
// rtl/scan_chain_uart_client.sv - UART-to-scan-chain write bridge with 8N1 transceiver
//
// Optional feature macro: SCANCHAIN_UART_RX_TIMEOUT_EN (partial-packet receive watchdog).
//
// scan_chain_uart_client ports:
//   clk            in   1    system clock
//   reset          in   1    asynchronous active-low reset
//   uart_rx        in   1    serial input from host (idle high)
//   uart_tx        out  1    serial output to host (idle high)
//   write_valid    out  1    one-cycle write request toward the scan chain
//   write_ready    in   1    scan chain accepts the write
//   write_addr     out  12   scan-chain address
//   write_payload  out  169  scan-chain data
//   write_reset    out  1    reset flag carried in the packet
//
// uart / uart_receiver / uart_transmitter: 8N1 LSB-first transceiver with a
// one-byte receive buffer (rx_tdata/rx_tvalid/rx_tready) and a transmit
// byte port (tx_tdata/tx_tvalid/tx_tready).

module uart_receiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic       rx_tready
);
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(BIT_CYCLES / 2);

    logic          rx_meta;
    logic          rx_sync;
    logic          busy;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            busy      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_tdata  <= '0;
            rx_tvalid <= 1'b0;
        end else begin
            rx_meta <= serial_in;
            rx_sync <= rx_meta;
            if (rx_tvalid && rx_tready) begin
                rx_tvalid <= 1'b0;
            end
            if (!busy) begin
                // Falling edge: wait half a bit so every later sample is mid-bit.
                if (!rx_sync) begin
                    busy    <= 1'b1;
                    cnt     <= HALF_BIT;
                    bit_idx <= '0;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= BIT_LAST;
                if (bit_idx == 4'd0) begin
                    // Start bit no longer low at mid-bit: treat as a glitch.
                    if (rx_sync) begin
                        busy <= 1'b0;
                    end else begin
                        bit_idx <= 4'd1;
                    end
                end else if (bit_idx != 4'd9) begin
                    shreg   <= {rx_sync, shreg[7:1]};
                    bit_idx <= bit_idx + 4'd1;
                end else begin
                    busy <= 1'b0;
                    // Framing errors are dropped; a full buffer drops the new byte.
                    if (rx_sync && (!rx_tvalid || rx_tready)) begin
                        rx_tdata  <= shreg;
                        rx_tvalid <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

module uart_transmitter #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready,
    output logic       serial_out
);
    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);

    logic [8:0]    shreg;
    logic [3:0]    bits_left;
    logic [CW-1:0] cnt;

    assign tx_tready = (bits_left == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            serial_out <= 1'b1;
            shreg      <= '1;
            bits_left  <= '0;
            cnt        <= '0;
        end else if (tx_tvalid && tx_tready) begin
            // Start bit goes out now; data bits then the stop bit are queued.
            serial_out <= 1'b0;
            shreg      <= {1'b1, tx_tdata};
            bits_left  <= 4'd10;
            cnt        <= BIT_LAST;
        end else if (bits_left != 4'd0) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt       <= BIT_LAST;
                bits_left <= bits_left - 4'd1;
                if (bits_left != 4'd1) begin
                    serial_out <= shreg[0];
                    shreg      <= {1'b1, shreg[8:1]};
                end
            end
        end
    end
endmodule

module uart #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    output logic       serial_out,
    output logic [7:0] rx_tdata,
    output logic       rx_tvalid,
    input  logic       rx_tready,
    input  logic [7:0] tx_tdata,
    input  logic       tx_tvalid,
    output logic       tx_tready
);
    uart_receiver #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .serial_in (serial_in),
        .rx_tdata  (rx_tdata),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready)
    );

    uart_transmitter #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_tx (
        .clk        (clk),
        .reset      (reset),
        .tx_tdata   (tx_tdata),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .serial_out (serial_out)
    );
endmodule

module scan_chain_uart_client #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         uart_rx,
    output logic         uart_tx,
    output logic         write_valid,
    input  logic         write_ready,
    output logic [11:0]  write_addr,
    output logic [168:0] write_payload,
    output logic         write_reset
);
    typedef enum logic [1:0] {
        RECV  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [183:0] pkt;
    logic [4:0]   byte_cnt;
    logic         pkt_done;
    logic [7:0]   ack_byte;

    logic [7:0]   rx_tdata;
    logic         rx_tvalid;
    logic         rx_tready;
    logic         tx_tvalid;
    logic         tx_tready;
    logic         rx_fire;
    logic         rx_timeout;

    // The two reserved packet bits are received but carry no meaning.
    logic         unused_reserved;
    assign unused_reserved = ^pkt[183:182];

    assign rx_fire = rx_tvalid && rx_tready;

    uart #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_uart (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (uart_rx),
        .serial_out (uart_tx),
        .rx_tdata   (rx_tdata),
        .rx_tvalid  (rx_tvalid),
        .rx_tready  (rx_tready),
        .tx_tdata   (ack_byte),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready)
    );

`ifdef SCANCHAIN_UART_RX_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = 32 * (CLOCK_FREQ / BAUD_RATE);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] wdog;
    logic          wdog_armed;

    // Only a partially received packet is guarded; an idle link never times out.
    assign wdog_armed = (state == RECV) && !pkt_done && (byte_cnt != 5'd0);
    assign rx_timeout = wdog_armed && !rx_fire && (wdog == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog <= '0;
        end else if (!wdog_armed || rx_fire || rx_timeout) begin
            wdog <= '0;
        end else begin
            wdog <= wdog + 1'b1;
        end
    end
`else
    assign rx_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        write_valid = 1'b0;
        rx_tready   = 1'b0;
        tx_tvalid   = 1'b0;
        case (state)
            RECV: begin
                // Hold off further bytes while the completed packet is latched.
                rx_tready = !pkt_done;
                if (pkt_done) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                write_valid = 1'b1;
                state_next  = RESP;
            end
            RESP: begin
                tx_tvalid = 1'b1;
                if (tx_tready) begin
                    state_next = RECV;
                end
            end
            default: begin
                state_next = RECV;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt           <= '0;
            byte_cnt      <= '0;
            pkt_done      <= 1'b0;
            ack_byte      <= '0;
            write_addr    <= '0;
            write_payload <= '0;
            write_reset   <= 1'b0;
        end else begin
            if (rx_fire) begin
                pkt <= {pkt[175:0], rx_tdata};
                if (byte_cnt == 5'd22) begin
                    pkt_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 5'd1;
                end
            end else if (rx_timeout) begin
                byte_cnt <= '0;
            end

            if (state == RECV && pkt_done) begin
                pkt_done      <= 1'b0;
                write_addr    <= pkt[11:0];
                write_payload <= pkt[180:12];
                write_reset   <= pkt[181];
            end

            // A write not taken in its single valid cycle is dropped, not retried.
            if (state == ISSUE) begin
                ack_byte <= {7'd0, write_ready};
            end

            if (state == RESP && tx_tready) begin
                byte_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_scan_chain_uart_client.sv
// tb/tb_scan_chain_uart_client.sv - scoreboard bench for scan_chain_uart_client
module tb_scan_chain_uart_client;
    localparam int BIT = 8;

    typedef struct packed {
        logic [7:0]   ack;
        logic         rst;
        logic [168:0] pl;
        logic [11:0]  addr;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         uart_rx;
    logic         uart_tx;
    logic         write_valid;
    logic         write_ready;
    logic [11:0]  write_addr;
    logic [168:0] write_payload;
    logic         write_reset;

    int total = 0;
    int bad = 0;
    int writes_seen = 0;
    int acks_seen = 0;
    int pkts_sent = 0;
    exp_t wq[$];
    exp_t aq[$];

    scan_chain_uart_client #(.CLOCK_FREQ(8_000_000), .BAUD_RATE(1_000_000)) dut (
        .clk           (clk),
        .reset         (reset),
        .uart_rx       (uart_rx),
        .uart_tx       (uart_tx),
        .write_valid   (write_valid),
        .write_ready   (write_ready),
        .write_addr    (write_addr),
        .write_payload (write_payload),
        .write_reset   (write_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [183:0] act, input logic [183:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cycles(BIT);
        end
        uart_rx = 1'b1;
        wait_cycles(BIT);
    endtask

    task automatic send_range(input logic [183:0] p, input int hi, input int lo);
        for (int k = hi; k >= lo; k--) begin
            send_byte(p[k*8 +: 8]);
        end
    endtask

    task automatic expect_write(input logic rst, input logic [168:0] pl, input logic [11:0] addr,
                                input logic rdy);
        exp_t e;
        e.ack  = rdy ? 8'h01 : 8'h00;
        e.rst  = rst;
        e.pl   = pl;
        e.addr = addr;
        wq.push_back(e);
        aq.push_back(e);
        pkts_sent++;
    endtask

    task automatic wait_acks(input int n);
        int t;
        t = 0;
        while (acks_seen < n && t < 400) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("ack_arrival", 184'(acks_seen), 184'(n));
    endtask

    task automatic send_pkt(input logic [1:0] rsv, input logic rst, input logic [168:0] pl,
                            input logic [11:0] addr, input logic rdy);
        write_ready = rdy;
        expect_write(rst, pl, addr, rdy);
        send_range({rsv, rst, pl, addr}, 22, 0);
        wait_acks(pkts_sent);
    endtask

    // Write monitor: every write_valid pulse pops one expected write.
    logic prev_wv = 1'b0;
    exp_t we;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (write_valid === 1'b1) begin
                writes_seen++;
                check("write_valid_one_cycle", 184'(prev_wv), 184'(0));
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: addr %h with no queued packet", write_addr);
                end else begin
                    we = wq.pop_front();
                    check("write_addr", 184'(write_addr), 184'(we.addr));
                    check("write_payload", 184'(write_payload), 184'(we.pl));
                    check("write_reset", 184'(write_reset), 184'(we.rst));
                end
            end
            prev_wv = write_valid;
        end else begin
            prev_wv = 1'b0;
        end
    end

    // Ack monitor: decode each serial frame on uart_tx and compare to the queue.
    initial begin
        logic [7:0] b;
        exp_t ae;
        wait (reset === 1'b1);
        forever begin
            @(negedge uart_tx);
            repeat (4) @(negedge clk);
            check("ack_start_bit", 184'(uart_tx), 184'(0));
            for (int i = 0; i < 8; i++) begin
                repeat (BIT) @(negedge clk);
                b[i] = uart_tx;
            end
            repeat (BIT) @(negedge clk);
            check("ack_stop_bit", 184'(uart_tx), 184'(1));
            if (aq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: byte %h with no queued packet", b);
            end else begin
                ae = aq.pop_front();
                check("ack_byte", 184'(b), 184'(ae.ack));
                check("hold_addr", 184'(write_addr), 184'(ae.addr));
                check("hold_payload", 184'(write_payload), 184'(ae.pl));
                check("hold_reset", 184'(write_reset), 184'(ae.rst));
            end
            acks_seen++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    localparam logic [168:0] PL1 = 169'h0_CAFE_F00D_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    localparam logic [168:0] PL2 = 169'h1_5555_AAAA_0000_FFFF_1357_9BDF_2468_ACE0_8000_0001;
    localparam logic [168:0] PL3 = 169'h0_0000_0000_0000_0000_0000_0000_0000_0000_0000_00A5;
    localparam logic [168:0] PL4 = 169'h1_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [168:0] PL6 = 169'h0_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA;
    localparam logic [168:0] PL7 = 169'h0_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F0F_F0F0;
    localparam logic [168:0] PL8 = 169'h1_8765_4321_0000_1111_2222_3333_4444_5555_6666_7777;

    initial begin
        reset       = 1'b0;
        uart_rx     = 1'b1;
        write_ready = 1'b0;
        wait_cycles(5);
        check("reset_write_valid", 184'(write_valid), 184'(0));
        check("reset_write_addr", 184'(write_addr), 184'(0));
        check("reset_write_payload", 184'(write_payload), 184'(0));
        check("reset_write_reset", 184'(write_reset), 184'(0));
        check("reset_uart_tx", 184'(uart_tx), 184'(1));
        reset = 1'b1;
        wait_cycles(20);

        send_pkt(2'b00, 1'b0, PL1, 12'h3A5, 1'b1);
        send_pkt(2'b00, 1'b0, PL2, 12'h0C3, 1'b0);
        send_pkt(2'b00, 1'b1, PL3, 12'h001, 1'b1);
        send_pkt(2'b00, 1'b0, PL4, 12'h800, 1'b1);
        send_pkt(2'b11, 1'b0, {169{1'b1}}, 12'hFFF, 1'b1);
        send_pkt(2'b10, 1'b1, PL3, 12'h7E7, 1'b1);

        // Abandon a packet part way with reset; only the following one may land.
        send_range({2'b00, 1'b1, PL6, 12'h456}, 22, 13);
        reset = 1'b0;
        wait_cycles(3);
        check("midpkt_reset_addr", 184'(write_addr), 184'(0));
        check("midpkt_reset_uart_tx", 184'(uart_tx), 184'(1));
        reset = 1'b1;
        wait_cycles(4 * BIT);
        send_pkt(2'b00, 1'b0, PL7, 12'h9AB, 1'b1);

`ifdef SCANCHAIN_UART_RX_TIMEOUT_EN
        send_range({2'b00, 1'b1, PL6, 12'h456}, 22, 18);
        wait_cycles(40 * BIT);
        send_pkt(2'b00, 1'b1, PL8, 12'h5C2, 1'b1);
`else
        // Without the watchdog a stalled packet simply resumes.
        write_ready = 1'b1;
        expect_write(1'b1, PL8, 12'h5C2, 1'b1);
        send_range({2'b00, 1'b1, PL8, 12'h5C2}, 22, 18);
        wait_cycles(40 * BIT);
        send_range({2'b00, 1'b1, PL8, 12'h5C2}, 17, 0);
        wait_acks(pkts_sent);
`endif

        wait_cycles(30 * BIT);
        check("writes_total", 184'(writes_seen), 184'(pkts_sent));
        check("acks_total", 184'(acks_seen), 184'(pkts_sent));
        check("write_queue_empty", 184'(wq.size()), 184'(0));
        check("ack_queue_empty", 184'(aq.size()), 184'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
